// File: rtl/add_seq_param_if.sv
// Operand/result handshake bundle for the chunked sequential adder.
// The master side presents operands and consumes results; the slave side is the adder.
interface add_seq_param_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] r1;
  logic [WIDTH-1:0] r2;
  logic             op_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] r_result_bus;
  logic             carry_out;
  logic             overflow;

  modport master (
    output in_valid, r1, r2, op_sub, out_ready,
    input  in_ready, out_valid, r_result_bus, carry_out, overflow
  );

  modport slave (
    input  in_valid, r1, r2, op_sub, out_ready,
    output in_ready, out_valid, r_result_bus, carry_out, overflow
  );
endinterface

// File: rtl/add_seq_param.sv
// Sequential add/subtract: one CHUNK-bit slice per clock, ripple carry held in a register.
// Results are published only when the last slice completes and held until taken.
//
// state | meaning
// IDLE  | ready for operands; last completed result stays on r_result_bus
// RUN   | adding slice idx each edge, carry propagated through carry_q
// DONE  | result valid, held until out_ready
module add_seq_param #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic           clk,
  input logic           rst,
  add_seq_param_if.slave bus
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int MSB   = WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             carry_out_q;
  logic             ovf_q;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      base;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic             last_chunk;
  logic             in_ready;
  logic             out_valid;
  logic             accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last_chunk) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept     = (state == IDLE) && bus.in_valid;
  assign last_chunk = (idx_q == IDX_W'(N - 1));
  assign base       = 32'(idx_q) * CHUNK;

  always_comb begin
    a_chunk   = a_q[base +: CHUNK];
    b_chunk   = b_q[base +: CHUNK];
    chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
    acc_nxt   = acc_q;
    acc_nxt[base +: CHUNK] = chunk_sum[CHUNK-1:0];
  end

  // b_q holds the already-inverted operand for subtract, so the +1 comes in via carry_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      ovf_q       <= 1'b0;
      idx_q       <= '0;
    end else if (accept) begin
      a_q     <= bus.r1;
      b_q     <= bus.op_sub ? ~bus.r2 : bus.r2;
      carry_q <= bus.op_sub;
      acc_q   <= '0;
      idx_q   <= '0;
    end else if (state == RUN) begin
      acc_q   <= acc_nxt;
      carry_q <= chunk_sum[CHUNK];
      idx_q   <= idx_q + 1'b1;
      if (last_chunk) begin
        result_q    <= acc_nxt;
        carry_out_q <= chunk_sum[CHUNK];
        ovf_q       <= (a_q[MSB] == b_q[MSB]) && (acc_nxt[MSB] != a_q[MSB]);
      end
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid;
  assign bus.r_result_bus = result_q;
  assign bus.carry_out    = carry_out_q;
  assign bus.overflow     = ovf_q;

endmodule

// File: tb/tb_add_seq_param.sv
// Bench for add_seq_param: directed vector table, backpressure/reset sequences and
// random operands against an integer reference model, at 16/4 and 32/8.
module tb_add_seq_param;

  logic clk = 1'b0;
  logic rst;
  int   pass_cnt = 0;
  int   total = 0;

  always #5 clk = ~clk;

  add_seq_param_if #(.WIDTH(16)) i16 ();
  add_seq_param_if #(.WIDTH(32)) i32 ();

  add_seq_param #(.WIDTH(16), .CHUNK(4)) dut16 (.clk(clk), .rst(rst), .bus(i16));
  add_seq_param #(.WIDTH(32), .CHUNK(8)) dut32 (.clk(clk), .rst(rst), .bus(i32));

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] res;
    logic        c;
    logic        o;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
  endtask

  // Integer reference: signed/unsigned range checks instead of bit tricks.
  function automatic void model(input int w, input longint a, input longint b, input bit sub,
                                output longint res, output bit c, output bit o);
    longint m, h, sa, sb, s, ss;
    m   = longint'(1) << w;
    h   = m >> 1;
    sa  = (a >= h) ? a - m : a;
    sb  = (b >= h) ? b - m : b;
    s   = sub ? a - b : a + b;
    res = s & (m - 1);
    c   = sub ? (a >= b) : (s >= m);
    ss  = sub ? sa - sb : sa + sb;
    o   = (ss >= h) || (ss < -h);
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic sub,
                      input int stall, input bit toggle,
                      input logic [15:0] er, input logic ec, input logic eo);
    int cyc;
    check("idle_in_ready16", i16.in_ready, 1);
    i16.r1 = a; i16.r2 = b; i16.op_sub = sub; i16.in_valid = 1'b1; i16.out_ready = 1'b0;
    @(negedge clk);
    i16.in_valid = toggle; i16.r1 = ~a; i16.r2 = ~b; i16.op_sub = ~sub;
    check("run_in_ready16", i16.in_ready, 0);
    cyc = 0;
    while (!i16.out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("latency16", cyc, 4);
    check("result16", i16.r_result_bus, er);
    check("carry16", i16.carry_out, ec);
    check("ovf16", i16.overflow, eo);
    for (int k = 0; k < stall; k++) begin
      if (toggle) begin
        i16.r1 = 16'($urandom); i16.r2 = 16'($urandom); i16.in_valid = ~i16.in_valid;
      end
      @(negedge clk);
      if (toggle) begin
        check("hold_valid16", i16.out_valid, 1);
        check("hold_ready16", i16.in_ready, 0);
        check("hold_result16", i16.r_result_bus, er);
        check("hold_carry16", i16.carry_out, ec);
        check("hold_ovf16", i16.overflow, eo);
      end
    end
    i16.out_ready = 1'b1; i16.in_valid = toggle;
    @(negedge clk);
    check("drop_valid16", i16.out_valid, 0);
    check("back_idle16", i16.in_ready, 1);
    i16.out_ready = 1'b0; i16.in_valid = 1'b0;
  endtask

  task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic sub,
                      input int stall, input logic [31:0] er, input logic ec, input logic eo);
    int cyc;
    check("idle_in_ready32", i32.in_ready, 1);
    i32.r1 = a; i32.r2 = b; i32.op_sub = sub; i32.in_valid = 1'b1; i32.out_ready = 1'b0;
    @(negedge clk);
    i32.in_valid = 1'b0; i32.r1 = ~a; i32.r2 = ~b; i32.op_sub = ~sub;
    cyc = 0;
    while (!i32.out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("latency32", cyc, 4);
    repeat (stall) @(negedge clk);
    check("result32", i32.r_result_bus, er);
    check("carry32", i32.carry_out, ec);
    check("ovf32", i32.overflow, eo);
    i32.out_ready = 1'b1;
    @(negedge clk);
    check("drop_valid32", i32.out_valid, 0);
    i32.out_ready = 1'b0;
  endtask

  initial begin
    longint mres;
    bit     mc, mo;
    logic [31:0] ra, rb;
    logic   rs;
    bit     seen;

    vecs[0] = '{16'd2,     16'd4,     1'b0, 16'd6,     1'b0, 1'b0};
    vecs[1] = '{16'd34952, 16'd34952, 1'b0, 16'd4368,  1'b1, 1'b1};
    vecs[2] = '{16'd5,     16'd7,     1'b1, 16'd65534, 1'b0, 1'b0};
    vecs[3] = '{16'd32767, 16'd1,     1'b0, 16'd32768, 1'b0, 1'b1};
    vecs[4] = '{16'hFFFF,  16'd1,     1'b0, 16'd0,     1'b1, 1'b0};
    vecs[5] = '{16'h8000,  16'd1,     1'b1, 16'h7FFF,  1'b1, 1'b1};
    vecs[6] = '{16'd7,     16'd7,     1'b1, 16'd0,     1'b1, 1'b0};
    vecs[7] = '{16'd0,     16'd1,     1'b1, 16'hFFFF,  1'b0, 1'b0};
    vecs[8] = '{16'h1234,  16'h4321,  1'b0, 16'h5555,  1'b0, 1'b0};
    vecs[9] = '{16'd0,     16'd0,     1'b0, 16'd0,     1'b0, 1'b0};

    rst = 1'b1;
    i16.in_valid = 1'b0; i16.r1 = '0; i16.r2 = '0; i16.op_sub = 1'b0; i16.out_ready = 1'b0;
    i32.in_valid = 1'b0; i32.r1 = '0; i32.r2 = '0; i32.op_sub = 1'b0; i32.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", i16.in_ready, 1);
    check("rst_out_valid", i16.out_valid, 0);
    check("rst_result", i16.r_result_bus, 0);
    check("rst_carry", i16.carry_out, 0);
    check("rst_ovf", i16.overflow, 0);

    // Release reset and present operands together: first edge with rst=0 must accept.
    rst = 1'b0;
    for (int i = 0; i < 10; i++)
      op16(vecs[i].a, vecs[i].b, vecs[i].sub, i % 3, 1'b0, vecs[i].res, vecs[i].c, vecs[i].o);

    op16(16'h1234, 16'h4321, 1'b0, 10, 1'b1, 16'h5555, 1'b0, 1'b0);

    // Reset on the second RUN edge abandons the operation.
    i16.r1 = 16'h0F0F; i16.r2 = 16'h0101; i16.op_sub = 1'b0; i16.in_valid = 1'b1;
    @(negedge clk);
    i16.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", i16.in_ready, 1);
    check("midrst_out_valid", i16.out_valid, 0);
    check("midrst_result", i16.r_result_bus, 0);
    check("midrst_carry", i16.carry_out, 0);
    check("midrst_ovf", i16.overflow, 0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (i16.out_valid) seen = 1'b1;
    end
    check("midrst_no_valid", seen, 0);
    op16(16'd100, 16'd200, 1'b0, 0, 1'b0, 16'd300, 1'b0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
      model(16, longint'(ra[15:0]), longint'(rb[15:0]), rs, mres, mc, mo);
      op16(ra[15:0], rb[15:0], rs, $urandom_range(0, 3), 1'b0, mres[15:0], mc, mo);
    end

    op32(32'hFFFFFFFF, 32'd1, 1'b0, 0, 32'd0, 1'b1, 1'b0);
    op32(32'h7FFFFFFF, 32'd1, 1'b0, 1, 32'h80000000, 1'b0, 1'b1);
    op32(32'd5, 32'd7, 1'b1, 2, 32'hFFFFFFFE, 1'b0, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
      model(32, longint'(ra), longint'(rb), rs, mres, mc, mo);
      op32(ra, rb, rs, $urandom_range(0, 3), mres[31:0], mc, mo);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
